// File: rtl/div_pkg.sv
// Shared types and constants for the radix-2 restoring divider.
//   div_state_t : controller states (IDLE, BUSY, DONE)
//   DIV_ITERS   : iterations per divide (one quotient bit per cycle)
//   CNT_W       : iteration counter width
//   condNeg     : conditional two's-complement negate
package div_pkg;

    localparam int DIV_ITERS = 32;
    localparam int CNT_W     = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

    function automatic logic [31:0] condNeg(input logic [31:0] val, input logic neg);
        return neg ? (~val + 32'd1) : val;
    endfunction

endpackage

// File: rtl/div_step.sv
// One iteration of restoring division (combinational).
// Ports:
//   remIn, qIn     : current working register halves {rem, q}
//   divisor        : divisor magnitude
//   remOut, qOut   : working register after shift, trial subtract and select
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] remIn,
    input  logic [WIDTH-1:0] qIn,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] remOut,
    output logic [WIDTH-1:0] qOut
);

    logic [WIDTH:0]   shifted;
    logic             fits;
    logic [WIDTH-1:0] diff;

    always_comb begin
        shifted = {remIn, qIn[WIDTH-1]};
        // The 33-bit trial difference is non-negative exactly when shifted >= divisor.
        // In that case the true difference is below the divisor, so the low
        // WIDTH bits of the subtraction are the complete result.
        fits    = (shifted >= {1'b0, divisor});
        diff    = shifted[WIDTH-1:0] - divisor;
        if (fits) begin
            remOut = diff;
            qOut   = {qIn[WIDTH-2:0], 1'b1};
        end else begin
            remOut = shifted[WIDTH-1:0];
            qOut   = {qIn[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_radix2.sv
// Iterative 32-bit radix-2 restoring divider (DIV/DIVU) for the execute stage.
// Ports:
//   clk, resetn           : clock, synchronous active-low reset
//   start_i, signed_i     : divide request (held while stalled), 1 = signed
//   a_i, b_i              : dividend, divisor
//   cancel_i              : flush, aborts any operation in flight
//   div_stall_o           : stall request to the hazard unit
//   ready_o               : one-cycle result-valid pulse
//   quot_o, rem_o         : quotient (to LO), remainder (to HI)
// Build option: DIV_ZERO_FASTPATH_EN finishes a zero-divisor divide in one cycle.
//
// state | meaning
// IDLE  | waiting for start_i; accepts operands on the edge
// BUSY  | one quotient bit per cycle, 32 cycles
// DONE  | results registered, ready_o pulses, start_i ignored
module div_radix2 import div_pkg::*; #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cancel_i,
    output logic             div_stall_o,
    output logic             ready_o,
    output logic [WIDTH-1:0] quot_o,
    output logic [WIDTH-1:0] rem_o
);

    div_state_t       state, stateNext;
    logic [CNT_W-1:0] iterCnt;
    logic [WIDTH-1:0] remReg, qReg, divisorReg;
    logic             isSigned, signA, signB;

    logic [WIDTH-1:0] magA, magB;
    logic [WIDTH-1:0] stepRem, stepQ;
    logic             lastIter;

    assign magA     = condNeg(a_i, signed_i & a_i[WIDTH-1]);
    assign magB     = condNeg(b_i, signed_i & b_i[WIDTH-1]);
    assign lastIter = (iterCnt == CNT_W'(DIV_ITERS - 1));

    div_step #(.WIDTH(WIDTH)) uStep (
        .remIn   (remReg),
        .qIn     (qReg),
        .divisor (divisorReg),
        .remOut  (stepRem),
        .qOut    (stepQ)
    );

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (start_i) begin
`ifdef DIV_ZERO_FASTPATH_EN
                    stateNext = (b_i == '0) ? DONE : BUSY;
`else
                    stateNext = BUSY;
`endif
                end
            end
            BUSY:    if (lastIter) stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
        if (cancel_i) stateNext = IDLE;
    end

    assign div_stall_o = ((state == IDLE) && start_i && !cancel_i) || (state == BUSY);
    assign ready_o     = (state == DONE);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= IDLE;
            iterCnt    <= '0;
            remReg     <= '0;
            qReg       <= '0;
            divisorReg <= '0;
            isSigned   <= 1'b0;
            signA      <= 1'b0;
            signB      <= 1'b0;
            quot_o     <= '0;
            rem_o      <= '0;
        end else begin
            state <= stateNext;
            // A flush freezes everything except the state, so the previous
            // result stays on quot_o/rem_o.
            if (!cancel_i) begin
                case (state)
                    IDLE: begin
                        if (start_i) begin
                            isSigned   <= signed_i;
                            signA      <= a_i[WIDTH-1];
                            signB      <= b_i[WIDTH-1];
                            divisorReg <= magB;
                            remReg     <= '0;
                            qReg       <= magA;
                            iterCnt    <= '0;
`ifdef DIV_ZERO_FASTPATH_EN
                            if (b_i == '0) begin
                                quot_o <= (signed_i && a_i[WIDTH-1]) ? WIDTH'(1) : '1;
                                rem_o  <= a_i;
                            end
`endif
                        end
                    end
                    BUSY: begin
                        remReg  <= stepRem;
                        qReg    <= stepQ;
                        iterCnt <= iterCnt + CNT_W'(1);
                        if (lastIter) begin
                            quot_o <= condNeg(stepQ, isSigned & (signA ^ signB));
                            rem_o  <= condNeg(stepRem, isSigned & signA);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_div_radix2.sv
module tb_div_radix2;

    logic        clk = 1'b0;
    logic        resetn, start_i, signed_i, cancel_i;
    logic [31:0] a_i, b_i;
    logic        div_stall_o, ready_o;
    logic [31:0] quot_o, rem_o;

    int errors = 0;
    int checks = 0;

`ifdef DIV_ZERO_FASTPATH_EN
    localparam int ZERO_LAT = 1;
`else
    localparam int ZERO_LAT = 33;
`endif

    div_radix2 #(.WIDTH(32)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .start_i     (start_i),
        .signed_i    (signed_i),
        .a_i         (a_i),
        .b_i         (b_i),
        .cancel_i    (cancel_i),
        .div_stall_o (div_stall_o),
        .ready_o     (ready_o),
        .quot_o      (quot_o),
        .rem_o       (rem_o)
    );

    always #5 clk = ~clk;

    // Reference: plain arithmetic with the architected special cases.
    function automatic void model(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
        int sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        if (b == 32'd0) begin
            q = (sgn && sa < 0) ? 32'd1 : 32'hFFFF_FFFF;
            r = a;
        end else if (!sgn) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else begin
            q = 32'(sa / sb);
            r = 32'(sa % sb);
        end
    endfunction

    task automatic runOne(input logic sgn, input logic [31:0] a, input logic [31:0] b, input string name);
        logic [31:0] eq, er;
        int stalls, lat, expLat;
        model(sgn, a, b, eq, er);
        expLat = (b == 32'd0) ? ZERO_LAT : 33;
        @(negedge clk);
        start_i = 1'b1; signed_i = sgn; a_i = a; b_i = b;
        stalls = 0; lat = -1;
        for (int c = 0; c < 100; c++) begin
            #1;
            if (ready_o) begin
                lat = c;
                break;
            end
            if (div_stall_o) stalls++;
            @(negedge clk);
        end
        checks++;
        if (lat !== expLat) begin
            errors++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, expLat);
        end
        checks++;
        if (stalls !== expLat) begin
            errors++;
            $display("FAIL %s stall cycles: got %0d expected %0d", name, stalls, expLat);
        end
        checks++;
        if (quot_o !== eq) begin
            errors++;
            $display("FAIL %s quot (a=%h b=%h s=%0d): got %h expected %h", name, a, b, sgn, quot_o, eq);
        end
        checks++;
        if (rem_o !== er) begin
            errors++;
            $display("FAIL %s rem (a=%h b=%h s=%0d): got %h expected %h", name, a, b, sgn, rem_o, er);
        end
        @(negedge clk);
        start_i = 1'b0;
        #1;
        checks++;
        if (ready_o !== 1'b0 || div_stall_o !== 1'b0) begin
            errors++;
            $display("FAIL %s after-done: got ready=%b stall=%b expected 0 0", name, ready_o, div_stall_o);
        end
    endtask

    task automatic test_reset;
        resetn = 1'b0; start_i = 1'b0; signed_i = 1'b0; cancel_i = 1'b0; a_i = '0; b_i = '0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (div_stall_o !== 1'b0 || ready_o !== 1'b0) begin
            errors++;
            $display("FAIL reset ctl: got stall=%b ready=%b expected 0 0", div_stall_o, ready_o);
        end
        checks++;
        if (quot_o !== 32'd0 || rem_o !== 32'd0) begin
            errors++;
            $display("FAIL reset data: got q=%h r=%h expected 0 0", quot_o, rem_o);
        end
        resetn = 1'b1;
    endtask

    task automatic test_directed;
        runOne(1'b0, 32'd100, 32'd7, "divu_100_7");
        runOne(1'b1, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
        runOne(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "div_min_m1");
        runOne(1'b0, 32'd5, 32'd0, "divu_5_0");
        runOne(1'b1, 32'hFFFF_FFFB, 32'd0, "div_m5_0");
        runOne(1'b1, 32'd5, 32'd0, "div_5_0");
        runOne(1'b0, 32'hFFFF_FFFF, 32'd1, "divu_max_1");
    endtask

    task automatic test_random;
        logic [31:0] a, b;
        logic sgn;
        int mode;
        for (int i = 0; i < 24; i++) begin
            sgn  = 1'($urandom_range(0, 1));
            a    = $urandom;
            mode = $urandom_range(0, 4);
            case (mode)
                0:       b = $urandom;
                1:       b = $urandom_range(1, 15);
                2:       b = $urandom >> $urandom_range(1, 31);
                3:       b = 32'(-$urandom_range(1, 15));
                default: b = (i % 2 == 0) ? 32'd0 : 32'd1;
            endcase
            runOne(sgn, a, b, "random");
        end
    endtask

    task automatic test_cancel;
        bit sawReady;
        bit changed;
        runOne(1'b0, 32'd1000, 32'd3, "cancel_prior");
        @(negedge clk);
        start_i = 1'b1; signed_i = 1'b0; a_i = 32'd50; b_i = 32'd5;
        repeat (11) @(negedge clk);
        cancel_i = 1'b1; start_i = 1'b0;
        @(negedge clk);
        cancel_i = 1'b0;
        #1;
        checks++;
        if (div_stall_o !== 1'b0 || ready_o !== 1'b0) begin
            errors++;
            $display("FAIL cancel ctl: got stall=%b ready=%b expected 0 0", div_stall_o, ready_o);
        end
        sawReady = 1'b0; changed = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (ready_o) sawReady = 1'b1;
            if (quot_o !== 32'd333 || rem_o !== 32'd1) changed = 1'b1;
            @(negedge clk);
            #1;
        end
        checks++;
        if (sawReady !== 1'b0) begin
            errors++;
            $display("FAIL cancel ready: got pulse=%b expected 0", sawReady);
        end
        checks++;
        if (changed !== 1'b0) begin
            errors++;
            $display("FAIL cancel hold: got q=%h r=%h expected 0000014d 00000001", quot_o, rem_o);
        end
    endtask

    task automatic test_back_to_back;
        int pulses;
        logic [31:0] q1, r1, q2, r2;
        pulses = 0; q1 = '0; r1 = '0; q2 = '0; r2 = '0;
        @(negedge clk);
        start_i = 1'b1; signed_i = 1'b0; a_i = 32'd20; b_i = 32'd3;
        for (int c = 0; c < 100; c++) begin
            #1;
            if (ready_o) begin
                pulses++;
                if (pulses == 1) begin q1 = quot_o; r1 = rem_o; end
                else if (pulses == 2) begin q2 = quot_o; r2 = rem_o; end
            end
            @(negedge clk);
            if (pulses == 1) begin a_i = 32'd9; b_i = 32'd4; end
            if (pulses >= 2) start_i = 1'b0;
        end
        start_i = 1'b0;
        checks++;
        if (pulses !== 2) begin
            errors++;
            $display("FAIL b2b pulses: got %0d expected 2", pulses);
        end
        checks++;
        if (q1 !== 32'd6 || r1 !== 32'd2) begin
            errors++;
            $display("FAIL b2b first: got q=%h r=%h expected 6 2", q1, r1);
        end
        checks++;
        if (q2 !== 32'd2 || r2 !== 32'd1) begin
            errors++;
            $display("FAIL b2b second: got q=%h r=%h expected 2 1", q2, r2);
        end
    endtask

    task automatic test_reset_mid_busy;
        bit sawReady;
        @(negedge clk);
        start_i = 1'b1; signed_i = 1'b1; a_i = 32'd12345; b_i = 32'd7;
        repeat (6) @(negedge clk);
        resetn = 1'b0; start_i = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (div_stall_o !== 1'b0 || ready_o !== 1'b0 || quot_o !== 32'd0 || rem_o !== 32'd0) begin
            errors++;
            $display("FAIL mid-busy reset: got stall=%b ready=%b q=%h r=%h expected 0 0 0 0",
                     div_stall_o, ready_o, quot_o, rem_o);
        end
        resetn = 1'b1;
        sawReady = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            #1;
            if (ready_o) sawReady = 1'b1;
        end
        checks++;
        if (sawReady !== 1'b0) begin
            errors++;
            $display("FAIL mid-busy reset ready: got pulse=%b expected 0", sawReady);
        end
        runOne(1'b1, 32'hFFFF_FF9C, 32'd7, "after_reset");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_cancel();
        test_back_to_back();
        test_reset_mid_busy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/div_radix2.md
# div_radix2

Iterative 32-bit radix-2 restoring divider for the execute stage; it implements DIV/DIVU. It produces the `div_stallE` request consumed by the hazard unit, holding F/D/E stalled until the quotient and remainder are ready. Its results feed the HI/LO write path: quotient to LO, remainder to HI. An exception flush cancels an in-flight divide.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width; only 32 is supported.

Ports:
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `resetn`  in  1  synchronous, active-low reset.
- `start_i`  in  1  E-stage divide instruction present; held high while E is stalled.
- `signed_i`  in  1  1 = DIV, 0 = DIVU; sampled with the operands.
- `a_i`  in  32  dividend (rs value, already forwarded).
- `b_i`  in  32  divisor (rt value, already forwarded).
- `cancel_i`  in  1  flush (exception in M); aborts the current operation.
- `div_stall_o`  out  1  stall request to the hazard unit (`div_stallE`).
- `ready_o`  out  1  one-cycle pulse; results valid.
- `quot_o`  out  32  quotient, written to LO.
- `rem_o`  out  32  remainder, written to HI.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE → BUSY when `start_i & !cancel_i`.
  - Latch `signed_i` and the sign of `a_i` and `b_i`.
  - Latch magnitudes |a| and |b|; magnitudes are taken only when `signed_i=1`.
  - Clear the iteration counter and the 64-bit working register {rem[31:0], q[31:0]} = {0, |a|}.
- BUSY: one iteration per cycle.
  - Shift {rem,q} left by 1.
  - Compute the 33-bit trial difference {rem_hi} − {0,|b|}.
  - If non-negative: rem_hi ← difference and q[0] ← 1; otherwise restore and q[0] ← 0.
  - After iteration 31 (counter = 31), go to DONE.
- Entry to DONE applies the sign fix:
  - Quotient is negated if `signed & (sa ^ sb)`.
  - Remainder is negated if `signed & sa`.
  - `quot_o`/`rem_o` are registered on this edge.
- DONE → IDLE unconditionally; `start_i` is ignored in DONE, since it still belongs to the finishing instruction.
- `div_stall_o = (state==IDLE & start_i & !cancel_i) | state==BUSY`. It is 0 in DONE.
- `ready_o = (state==DONE)`.
- `cancel_i` in any state → IDLE on the next edge.
  - No `ready_o`; `quot_o`/`rem_o` keep their old values.
  - `cancel_i` takes priority over `start_i` and over completion.
- Divide by zero completes with defined values:
  - `quot_o` = (signed & sa) ? 32'h0000_0001 : 32'hFFFF_FFFF.
  - `rem_o` = `a_i`.
- −2^31 / −1 (signed): `quot_o` = 32'h8000_0000, `rem_o` = 0. No trap.

## Timing
- Reset (`resetn=0` at an edge) has priority over everything, including mid-BUSY:
  - State ← IDLE; counter, working register, `quot_o` and `rem_o` ← 0.
  - Outputs after reset: `div_stall_o`=0 (unless `start_i`), `ready_o`=0.
- Latency: the accept edge ends cycle 0, followed by 32 BUSY cycles and then DONE.
  - Cycles 0..32: stall = 1.
  - Cycle 33: `ready_o` = 1, stall = 0; the pipeline advances on that edge.
- Back-to-back divides: the next instruction's `start_i` is seen in IDLE at cycle 34, so there is no lost or duplicate operation.
- Outputs hold between operations; they are valid only while `ready_o` = 1.

## Configuration
- `DIV_ZERO_FASTPATH_EN` defined:
  - `b_i==0` at accept goes IDLE → DONE directly; the divide-by-zero values are loaded in DONE.
  - Stall covers only cycle 0; `ready_o` is asserted in cycle 1.
- Not defined: a zero divisor runs the full 32 iterations. The result values are identical (the algorithm yields them naturally); only latency differs.

## Structure
- Shared package `div_pkg`:
  - State enum `div_state_t` (IDLE, BUSY, DONE).
  - `DIV_ITERS` = 32 and counter width 5.
- One sub-module `div_step`: combinational single iteration (shift, 33-bit trial subtract, select). The top holds the FSM, counter, sign handling and output registers.

## Test plan
- DIVU 100 / 7 → after 33 stall cycles, `ready_o` pulse; quot 0x0000000E, rem 0x00000002.
- DIV −7 / 2 → quot 0xFFFFFFFD, rem 0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF → quot 0x80000000, rem 0.
- Divide by zero, checked with and without `DIV_ZERO_FASTPATH_EN`; expected latency is 1 cycle with the macro, 33 without:
  - DIVU 5/0 → quot 0xFFFFFFFF, rem 5.
  - DIV −5/0 → quot 0x00000001, rem 0xFFFFFFFB.
- `cancel_i` pulsed at BUSY iteration 10 → IDLE next cycle, stall 0, no `ready_o`, outputs unchanged from the prior result.
- Two consecutive DIVU (20/3 then 9/4) with `start_i` held continuously → exactly two `ready_o` pulses; results 6 r2 then 2 r1.
- `resetn` low mid-BUSY → next cycle IDLE, all outputs 0.
